// File: rtl/hub75_pkg.sv
// Shared constants, pixel layout, bus payload and FSM encoding for the HUB75 capture block.
package hub75_pkg;

    localparam int unsigned WIDTH          = 32;
    localparam int unsigned ROWS_PER_GROUP = 16;
    localparam int unsigned FRAME_W        = 32;
    localparam int unsigned FRAME_H        = 32;

    localparam int unsigned PIX_W = 3;
    localparam int unsigned PIX_R = 2;
    localparam int unsigned PIX_G = 1;
    localparam int unsigned PIX_B = 0;

    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned CNT_MAX = 63;
    localparam int unsigned FB_AW   = 10;
    localparam int unsigned FC_W    = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_COPY = 1'b1;

    // One sample of the panel bus as seen by the receiver.
    typedef struct packed {
        logic             r1;
        logic             g1;
        logic             b1;
        logic             r2;
        logic             g2;
        logic             b2;
        logic [ROW_W-1:0] row_addr;
        logic             sclk;
        logic             lat;
        logic             oe;
    } hub_bus_t;

endpackage

// File: rtl/hub75_rx_fb.sv
// 1024x3 frame buffer, one write port and one synchronous read port; the write port
// stores a top/bottom pixel pair per address, so the array is kept as two half-frame banks.
module hub75_rx_fb
    import hub75_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [FB_AW-2:0] waddr,
    input  logic [PIX_W-1:0] wdata_top,
    input  logic [PIX_W-1:0] wdata_bot,
    input  logic [FB_AW-1:0] raddr,
    output logic [PIX_W-1:0] rdata
);

    localparam int unsigned HALF_DEPTH = FRAME_W * FRAME_H / 2;

    logic [PIX_W-1:0] mem_top [HALF_DEPTH];
    logic [PIX_W-1:0] mem_bot [HALF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_top[waddr] <= wdata_top;
            mem_bot[waddr] <= wdata_bot;
        end
    end

    // Registered read; a same-cycle write to the address returns the old contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (raddr[FB_AW-1]) begin
            rdata <= mem_bot[raddr[FB_AW-2:0]];
        end else begin
            rdata <= mem_top[raddr[FB_AW-2:0]];
        end
    end

endmodule

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: rebuilds the displayed 32x32 image from the panel bus with exact shift-register
// semantics. Define HUB75_RX_SYNC_EN to add a 2-flop synchronizer for an asynchronous panel bus.
module hub75_rx_capture
    import hub75_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hub_r1,
    input  logic             hub_g1,
    input  logic             hub_b1,
    input  logic             hub_r2,
    input  logic             hub_g2,
    input  logic             hub_b2,
    input  logic [ROW_W-1:0] hub_row_addr,
    input  logic             hub_clk,
    input  logic             hub_lat,
    input  logic             hub_oe,
    input  logic [FB_AW-1:0] rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             frame_done,
    output logic [FC_W-1:0]  frame_count,
    output logic [15:0]      lit_rows,
    output logic             err_short,
    output logic             err_drop
);

    localparam int unsigned SR_W = WIDTH * PIX_W;

    hub_bus_t hub_raw, hub_in, hub_q;
    logic     sclk_d, lat_d;

    assign hub_raw = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
                      hub_row_addr, hub_clk, hub_lat, hub_oe};

`ifdef HUB75_RX_SYNC_EN
    hub_bus_t sync_1, sync_2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= hub_raw;
            sync_2 <= sync_1;
        end
    end

    assign hub_in = sync_2;
`else
    assign hub_in = hub_raw;
`endif

    // Input register plus delayed copies of the two strobes for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hub_q  <= '0;
            sclk_d <= 1'b0;
            lat_d  <= 1'b0;
        end else begin
            hub_q  <= hub_in;
            sclk_d <= hub_q.sclk;
            lat_d  <= hub_q.lat;
        end
    end

    logic             sclk_rise, lat_rise;
    logic [PIX_W-1:0] pix_top, pix_bot;
    logic [SR_W-1:0]  sr_top, sr_bot, sr_top_nxt, sr_bot_nxt;
    logic [SR_W-1:0]  hold_top, hold_bot;
    logic [CNT_W-1:0] shift_cnt, shift_cnt_inc, cnt_nxt;

    assign sclk_rise = hub_q.sclk & ~sclk_d;
    assign lat_rise  = hub_q.lat & ~lat_d;

    // Newest pixel enters at column WIDTH-1; column 0 falls off the end.
    always_comb begin
        pix_top        = '0;
        pix_bot        = '0;
        pix_top[PIX_R] = hub_q.r1;
        pix_top[PIX_G] = hub_q.g1;
        pix_top[PIX_B] = hub_q.b1;
        pix_bot[PIX_R] = hub_q.r2;
        pix_bot[PIX_G] = hub_q.g2;
        pix_bot[PIX_B] = hub_q.b2;
        sr_top_nxt     = sr_top;
        sr_bot_nxt     = sr_bot;
        shift_cnt_inc  = shift_cnt;
        if (sclk_rise) begin
            sr_top_nxt = {pix_top, sr_top[SR_W-1:PIX_W]};
            sr_bot_nxt = {pix_bot, sr_bot[SR_W-1:PIX_W]};
            if (shift_cnt != CNT_W'(CNT_MAX)) begin
                shift_cnt_inc = shift_cnt + 1'b1;
            end
        end
    end

    logic [0:0]       state, state_nxt;
    logic [COL_W-1:0] step, step_nxt;
    logic [ROW_W-1:0] hold_row;
    logic             row_valid;
    logic             latch_acc, drop, done_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = shift_cnt_inc;
        latch_acc = 1'b0;
        drop      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lat_rise) begin
                    latch_acc = 1'b1;
                    cnt_nxt   = '0;
                    step_nxt  = '0;
                    state_nxt = ST_COPY;
                end
            end
            ST_COPY: begin
                step_nxt = step + 1'b1;
                drop     = lat_rise;
                // frame_done is registered, so it is raised one step early to coincide with the last write.
                if (step == COL_W'(WIDTH - 2) && hold_row == ROW_W'(ROWS_PER_GROUP - 1)) begin
                    done_nxt = 1'b1;
                end
                if (step == COL_W'(WIDTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_cnt   <= '0;
            hold_row    <= '0;
            row_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_short   <= 1'b0;
            err_drop    <= 1'b0;
            lit_rows    <= '0;
        end else begin
            shift_cnt  <= cnt_nxt;
            frame_done <= done_nxt;
            if (done_nxt) begin
                frame_count <= frame_count + 1'b1;
            end
            if (latch_acc) begin
                hold_row  <= hub_q.row_addr;
                row_valid <= 1'b1;
                if (shift_cnt_inc != CNT_W'(WIDTH)) begin
                    err_short <= 1'b1;
                end
            end
            if (drop) begin
                err_drop <= 1'b1;
            end
            if (frame_done) begin
                lit_rows <= '0;
            end else if (row_valid && !hub_q.oe) begin
                lit_rows[hold_row] <= 1'b1;
            end
        end
    end

    // Shift and holding registers carry pixel data only and are left unreset.
    always_ff @(posedge clk) begin
        sr_top <= sr_top_nxt;
        sr_bot <= sr_bot_nxt;
        if (latch_acc) begin
            hold_top <= sr_top_nxt;
            hold_bot <= sr_bot_nxt;
        end
    end

    logic             fb_we;
    logic [FB_AW-2:0] fb_waddr;
    logic [PIX_W-1:0] fb_wtop, fb_wbot;

    assign fb_we    = (state == ST_COPY);
    assign fb_waddr = {hold_row, step};
    assign fb_wtop  = hold_top[PIX_W*step +: PIX_W];
    assign fb_wbot  = hold_bot[PIX_W*step +: PIX_W];

    hub75_rx_fb u_fb (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (fb_we),
        .waddr     (fb_waddr),
        .wdata_top (fb_wtop),
        .wdata_bot (fb_wbot),
        .raddr     (rd_addr),
        .rdata     (rd_data)
    );

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Self-checking bench for hub75_rx_capture: directed vector table, multi-cycle corner
// sequences and randomized frames against a queue/array image model.
`timescale 1ns/1ps
module tb_hub75_rx_capture;
    import hub75_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic [3:0]  hub_row_addr;
    logic        hub_clk, hub_lat, hub_oe;
    logic [9:0]  rd_addr;
    logic [2:0]  rd_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] lit_rows;
    logic        err_short, err_drop;

    always #5 clk = ~clk;

    hub75_rx_capture dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hub_r1       (hub_r1),
        .hub_g1       (hub_g1),
        .hub_b1       (hub_b1),
        .hub_r2       (hub_r2),
        .hub_g2       (hub_g2),
        .hub_b2       (hub_b2),
        .hub_row_addr (hub_row_addr),
        .hub_clk      (hub_clk),
        .hub_lat      (hub_lat),
        .hub_oe       (hub_oe),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .lit_rows     (lit_rows),
        .err_short    (err_short),
        .err_drop     (err_drop)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_pulses;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) done_pulses <= 0;
        else if (frame_done) done_pulses <= done_pulses + 1;
    end

    // Reference model: last WIDTH pixels shifted, expected image, flags and counters.
    logic [2:0]  exp_fb [1024];
    logic [2:0]  q_top[$];
    logic [2:0]  q_bot[$];
    int          m_cnt, m_last, m_fc;
    bit          m_busy;
    logic        m_short, m_drop;
    logic [15:0] m_lit;
    logic [2:0]  px_top [64];
    logic [2:0]  px_bot [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_latch(input logic [3:0] row);
        if (m_busy && (cyc - m_last) <= 32) begin
            m_drop = 1'b1;
        end else begin
            if (m_cnt != 32) m_short = 1'b1;
            m_cnt  = 0;
            m_busy = 1'b1;
            m_last = cyc;
            for (int c = 0; c < 32; c++) begin
                exp_fb[int'(row) * 32 + c]        = q_top[c];
                exp_fb[(int'(row) + 16) * 32 + c] = q_bot[c];
            end
            if (row == 4'd15) m_fc++;
        end
    endtask

    task automatic drive_shift(input logic [2:0] t, input logic [2:0] b,
                               input bit with_lat, input logic [3:0] row);
        {hub_r1, hub_g1, hub_b1} = t;
        {hub_r2, hub_g2, hub_b2} = b;
        hub_clk = 1'b1;
        q_top.push_back(t);
        q_bot.push_back(b);
        if (q_top.size() > 32) void'(q_top.pop_front());
        if (q_bot.size() > 32) void'(q_bot.pop_front());
        if (m_cnt < 63) m_cnt++;
        if (with_lat) begin
            hub_row_addr = row;
            hub_lat      = 1'b1;
            model_latch(row);
        end
        tick();
        hub_clk = 1'b0;
        hub_lat = 1'b0;
        tick();
    endtask

    task automatic drive_latch(input logic [3:0] row);
        hub_row_addr = row;
        hub_lat      = 1'b1;
        model_latch(row);
        tick();
        hub_lat = 1'b0;
        tick();
    endtask

    task automatic drive_row(input int n, input bit coincide, input logic [3:0] row);
        for (int i = 0; i < n; i++) drive_shift(px_top[i], px_bot[i], coincide && (i == n - 1), row);
        if (!coincide) drive_latch(row);
    endtask

    // Show the row briefly, let the copy finish, then compare status against the model.
    task automatic row_finish(input logic [3:0] row);
        hub_oe = 1'b0;
        m_lit[row] = 1'b1;
        tick();
        tick();
        hub_oe = 1'b1;
        repeat (36) tick();
        if (row == 4'd15) m_lit = '0;
        check($sformatf("row%0d_lit_rows", row), 32'(lit_rows), 32'(m_lit));
        check($sformatf("row%0d_err_short", row), 32'(err_short), 32'(m_short));
        check($sformatf("row%0d_err_drop", row), 32'(err_drop), 32'(m_drop));
        check($sformatf("row%0d_frame_count", row), 32'(frame_count), 32'(m_fc));
        check($sformatf("row%0d_done_pulses", row), 32'(done_pulses), 32'(m_fc));
    endtask

    task automatic read_px(input logic [9:0] a, output logic [2:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hub_clk = 1'b0;
        hub_lat = 1'b0;
        hub_oe  = 1'b1;
        tick();
        tick();
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        check("reset_lit_rows", 32'(lit_rows), 32'd0);
        check("reset_err_short", 32'(err_short), 32'd0);
        check("reset_err_drop", 32'(err_drop), 32'd0);
        m_cnt = 0; m_busy = 1'b0; m_short = 1'b0; m_drop = 1'b0; m_fc = 0; m_lit = '0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_frame(input string tag);
        logic [2:0] d;
        int bad = 0;
        for (int a = 0; a < 1024; a++) begin
            read_px(10'(a), d);
            n_cmp++;
            if (d !== exp_fb[a]) begin
                n_err++;
                if (bad < 8) $display("FAIL %s_px[%0d]: got %0d, expected %0d", tag, a, d, exp_fb[a]);
                bad++;
            end
        end
    endtask

    typedef struct {
        int         nshift;
        bit         coincide;
        logic [3:0] row;
        logic [9:0] addr;
        logic [2:0] exp_px;
        logic       exp_short;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [2:0] d;
        int nsel[4];

        vecs[0] = '{32, 1'b0, 4'd5, 10'd169, 3'd1, 1'b0};
        vecs[1] = '{32, 1'b0, 4'd5, 10'd681, 3'd6, 1'b0};
        vecs[2] = '{34, 1'b0, 4'd0, 10'd0,   3'd2, 1'b1};
        vecs[3] = '{34, 1'b0, 4'd0, 10'd31,  3'd1, 1'b1};
        vecs[4] = '{34, 1'b0, 4'd0, 10'd512, 3'd5, 1'b1};
        vecs[5] = '{32, 1'b1, 4'd7, 10'd255, 3'd7, 1'b0};
        vecs[6] = '{32, 1'b1, 4'd7, 10'd767, 3'd0, 1'b0};
        nsel = '{32, 32, 33, 35};

        {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = '0;
        hub_row_addr = '0;
        rd_addr      = '0;
        do_reset();

        // Directed single-row vectors: col mod 8 on top, 7 - (col mod 8) on bottom.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < 64; i++) begin
                px_top[i] = 3'(i % 8);
                px_bot[i] = 3'(7 - (i % 8));
            end
            drive_row(vecs[v].nshift, vecs[v].coincide, vecs[v].row);
            repeat (40) tick();
            read_px(vecs[v].addr, d);
            check($sformatf("vec%0d_px", v), 32'(d), 32'(vecs[v].exp_px));
            check($sformatf("vec%0d_err_short", v), 32'(err_short), 32'(vecs[v].exp_short));
            check($sformatf("vec%0d_err_drop", v), 32'(err_drop), 32'd0);
            check($sformatf("vec%0d_frame_count", v), 32'(frame_count), 32'd0);
        end

        // Second latch 10 cycles after the first is dropped and row 9 keeps its data.
        do_reset();
        for (int i = 0; i < 64; i++) begin px_top[i] = 3'd3; px_bot[i] = 3'd4; end
        drive_row(32, 1'b0, 4'd9);
        repeat (40) tick();
        for (int i = 0; i < 64; i++) begin px_top[i] = 3'd5; px_bot[i] = 3'd2; end
        drive_row(32, 1'b0, 4'd2);
        repeat (8) tick();
        drive_latch(4'd9);
        repeat (40) tick();
        check("drop_err_drop", 32'(err_drop), 32'd1);
        check("drop_err_short", 32'(err_short), 32'd0);
        read_px(10'd68, d);
        check("drop_row2_top", 32'(d), 32'd5);
        read_px(10'd580, d);
        check("drop_row18_bot", 32'(d), 32'd2);
        read_px(10'd292, d);
        check("drop_row9_top", 32'(d), 32'd3);
        read_px(10'd804, d);
        check("drop_row25_bot", 32'(d), 32'd4);

        // Reset in the middle of the row-15 copy: no frame_done, counters restart.
        do_reset();
        for (int i = 0; i < 64; i++) begin px_top[i] = 3'd1; px_bot[i] = 3'd1; end
        drive_row(32, 1'b0, 4'd15);
        repeat (15) tick();
        do_reset();
        repeat (40) tick();
        check("abort_no_done", 32'(done_pulses), 32'd0);
        check("abort_frame_count", 32'(frame_count), 32'd0);

        // Full all-colour-6 loopback frame.
        for (int i = 0; i < 64; i++) begin px_top[i] = 3'b110; px_bot[i] = 3'b110; end
        for (int r = 0; r < 16; r++) begin
            drive_row(32, 1'b0, 4'(r));
            row_finish(4'(r));
        end
        check("frame6_frame_count", 32'(frame_count), 32'd1);
        check("frame6_done_pulses", 32'(done_pulses), 32'd1);
        check("frame6_err_short", 32'(err_short), 32'd0);
        check("frame6_err_drop", 32'(err_drop), 32'd0);
        begin
            int bad = 0;
            for (int a = 0; a < 1024; a++) begin
                read_px(10'(a), d);
                n_cmp++;
                if (d !== 3'b110) begin
                    n_err++;
                    if (bad < 8) $display("FAIL frame6_px[%0d]: got %0d, expected 6", a, d);
                    bad++;
                end
            end
        end

        // Randomized frames with varying shift counts and coincident shift/latch.
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 16; r++) begin
                int n;
                bit co;
                n  = nsel[$urandom_range(0, 3)];
                co = 1'($urandom_range(0, 1));
                for (int i = 0; i < 64; i++) begin
                    px_top[i] = 3'($urandom_range(0, 7));
                    px_bot[i] = 3'($urandom_range(0, 7));
                end
                drive_row(n, co, 4'(r));
                row_finish(4'(r));
            end
            check_frame($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hub75_rx_capture.md
# hub75_rx_capture

Receiving end of the HUB75 scan interface: samples the six colour lines, shift clock, latch, output-enable and row address as driven by the panel driver, and reconstructs the displayed 32x32 3-bit-per-pixel image in an internal frame buffer. It sits on the bench and debug side of the design: a loopback capture of the driver's outputs for self-check, and a readback port for an on-chip checker or host. It models panel shift-register semantics exactly, so mis-clocked rows show up in the captured image.

## Interface

- WIDTH, 32: columns per row, shift-register depth.
- ROWS_PER_GROUP, 16: row pairs per scan (1/16).
- clk  in  1  system clock, same domain as the driver.
- reset_n  in  1  asynchronous, active-low reset.
- hub_r1, hub_g1, hub_b1  in  1 each  top-half colour.
- hub_r2, hub_g2, hub_b2  in  1 each  bottom-half colour.
- hub_row_addr  in  4  row-pair address.
- hub_clk  in  1  shift clock; data is captured on its rising edge.
- hub_lat  in  1  latch; active high, acts on its rising edge.
- hub_oe  in  1  output enable, active low.
- rd_addr  in  10  pixel address, y*32+x, y 0..31.
- rd_data  out  3  {R,G,B} at rd_addr, 1-cycle latency.
- frame_done  out  1  one-cycle pulse after row pair 15 is written.
- frame_count  out  16  completed frames, wraps at 65535->0.
- lit_rows  out  16  bit n is set once row pair n has been latched and later shown (hub_oe low ≥1 cycle).
- err_short  out  1  sticky; a latch occurred with shift count ≠ WIDTH.
- err_drop  out  1  sticky; a latch arrived while a copy was busy.

## Operation

- Input stage: all hub_* signals are registered (see Configuration). Each edge detect compares the registered value with its one-cycle-delayed copy.
- Shift: on a detected hub_clk rise, the top and bottom 3-bit pixels taken from the same registered sample shift into two WIDTH-entry shift registers. The newest pixel sits at column WIDTH-1 and older pixels move toward column 0. Pixels shifted beyond WIDTH are discarded. shift_cnt counts shifts and saturates at 63.
- Latch: on a detected hub_lat rise in state IDLE:
  - snapshot both shift registers and hub_row_addr into holding registers;
  - set err_short if shift_cnt ≠ WIDTH;
  - clear shift_cnt; the shift register contents are kept;
  - go to COPY.
- A latch rise during COPY sets err_drop and is otherwise ignored; the holding registers are left unchanged.
- A hub_clk rise in the same cycle as a hub_lat rise: the shift is applied first, and the snapshot includes that pixel.
- FSM IDLE -> COPY -> IDLE. COPY lasts WIDTH cycles. At step c it writes top holding[c] to address row*32+c and bottom holding[c] to (row+16)*32+c. On the final step it returns to IDLE; if row = ROWS_PER_GROUP-1 it also pulses frame_done and increments frame_count.
- lit_rows: hub_oe low while the most recently latched row is r sets bit r. The vector clears on the frame_done pulse.
- Frame buffer: 1024x3, one write port and one read port. A read of an address written in the same cycle returns the old data.
- Reset values: all outputs are 0. The shift registers, holding registers and frame buffer are not reset and read as X until written; the bench must write before checking.
- Reset mid-COPY aborts the copy. The partially written row is left as-is.

## Timing

- Input registering adds 1 cycle (3 cycles with the macro) before an edge is seen.
- A pixel is in the shift register 1 cycle after its edge is detected.
- The first frame-buffer write happens 1 cycle after the latch is detected. The last write is WIDTH cycles after it. frame_done is asserted in the same cycle as the last write.
- rd_data is registered and valid the cycle after rd_addr.
- Minimum latch spacing without loss is WIDTH+1 cycles.

## Configuration

- HUB75_RX_SYNC_EN:
  - Defined: each hub_* input passes through a 2-flop synchronizer before the input register, so the block can capture an asynchronous external panel bus. Edge detection latency grows by 2 cycles.
  - Undefined: a single input register only, for same-clock loopback.
- Functional behaviour is otherwise identical in both builds.

## Structure

- Shared package hub75_pkg holds:
  - WIDTH, ROWS_PER_GROUP, FRAME_W=32, FRAME_H=32;
  - pixel bit positions R=2, G=1, B=0;
  - the FSM state encoding IDLE/COPY.
- One sub-module, hub75_rx_fb: the 1024x3 simple dual-port frame buffer with synchronous read, inferable as M9K.

## Test plan

- Loopback the driver with an all-colour-6 frame (R,G set) -> after frame_done, all 1024 reads return 3'b110, frame_count=1, err_short=0, err_drop=0.
- Drive 32 pixels with value = col mod 8 on top and 7 - (col mod 8) on bottom, then latch row 5 -> address 5*32+9 reads 1, address 21*32+9 reads 6.
- 34 shifts then latch row 0 -> columns 0..31 hold pixels 2..33, err_short=1.
- Second latch 10 cycles after the first -> err_drop=1, and only the first row is written.
- Shift and latch rising in the same cycle after 31 prior shifts -> the last pixel lands in column 31, err_short=0.
- Assert reset_n low midway through COPY of row 15 -> all outputs are 0 and no frame_done pulse occurs; the next full frame yields frame_count=1.
